// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD-to-7-segment display block.
// Segment constants are active-high {g,f,e,d,c,b,a}; polarity is applied by the top.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

    // One double-dabble iteration per input bit.
    localparam int ITER_COUNT = 8;
    localparam int ITER_W     = $clog2(ITER_COUNT + 1);

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Pre-shift correction so a nibble that would reach 10 carries into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bcd_seg_display_if.sv
// Conversion request/response bundle between the counter side and the display block.
interface bcd_seg_display_if;

    logic [7:0] bin_in;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg_hund;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    modport master (
        output bin_in, start,
        input  busy, done, bcd_hund, bcd_tens, bcd_ones, seg_hund, seg_tens, seg_ones
    );

    modport slave (
        input  bin_in, start,
        output busy, done, bcd_hund, bcd_tens, bcd_ones, seg_hund, seg_tens, seg_ones
    );

endinterface

// File: rtl/seg7_encode.sv
// Combinational digit-to-segment encoder, active-high {g,f,e,d,c,b,a}.
// Non-decimal nibbles and an asserted blank both give an unlit digit.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // NOTE: seg gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_display.sv
// Samples an 8-bit count, converts it to BCD with a sequential shift-add-3 engine,
// and registers blanked 7-segment patterns; triggered by start or a refresh timer.
module bcd_seg_display
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 12_000_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input logic              clk,
    input logic              rst,
    bcd_seg_display_if.slave dsp
);

    localparam logic [6:0] SEG_ZERO_OUT  = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
    localparam logic [6:0] SEG_BLANK_OUT = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [6:0] SEG_LEAD_RST  = BLANK_LEADING ? SEG_BLANK_OUT : SEG_ZERO_OUT;

    state_t            state;
    logic [7:0]        shreg;
    logic [11:0]       scratch;
    logic [ITER_W-1:0] iter;
    logic [11:0]       adjusted;
    logic              tick;
    logic              blank_hund;
    logic              blank_tens;
    logic [6:0]        pat_hund;
    logic [6:0]        pat_tens;
    logic [6:0]        pat_ones;

    // Free-running refresh timer; keeps counting while a conversion is in flight.
    generate
        if (REFRESH_DIV > 0) begin : g_refresh
            localparam int unsigned TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
            localparam logic [TW-1:0] LAST = TW'(REFRESH_DIV - 1);

            logic [TW-1:0] count;

            always_ff @(posedge clk) begin
                if (rst) begin
                    count <= '0;
                end else if (count == LAST) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            assign tick = (count == LAST);
        end else begin : g_no_refresh
            assign tick = 1'b0;
        end
    endgenerate

    always_comb begin
        adjusted = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    end

    assign blank_hund = BLANK_LEADING && (scratch[11:8] == 4'd0);
    assign blank_tens = BLANK_LEADING && (scratch[11:4] == 8'd0);

    seg7_encode u_enc_hund (.digit(scratch[11:8]), .blank(blank_hund), .seg(pat_hund));
    seg7_encode u_enc_tens (.digit(scratch[7:4]),  .blank(blank_tens), .seg(pat_tens));
    seg7_encode u_enc_ones (.digit(scratch[3:0]),  .blank(1'b0),       .seg(pat_ones));

    // NOTE: all state is updated with <= so every register sees pre-edge values, as hardware does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            scratch      <= '0;
            iter         <= '0;
            dsp.busy     <= 1'b0;
            dsp.done     <= 1'b0;
            dsp.bcd_hund <= 4'd0;
            dsp.bcd_tens <= 4'd0;
            dsp.bcd_ones <= 4'd0;
            dsp.seg_hund <= SEG_LEAD_RST;
            dsp.seg_tens <= SEG_LEAD_RST;
            dsp.seg_ones <= SEG_ZERO_OUT;
        end else begin
            dsp.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dsp.start || tick) begin
                        shreg    <= dsp.bin_in;
                        scratch  <= '0;
                        iter     <= '0;
                        dsp.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {adjusted[10:0], shreg, 1'b0};
                    iter             <= iter + 1'b1;
                    if (iter == ITER_W'(ITER_COUNT - 1)) begin
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    // Digits and segments update together so no partial result is ever shown.
                    dsp.bcd_hund <= scratch[11:8];
                    dsp.bcd_tens <= scratch[7:4];
                    dsp.bcd_ones <= scratch[3:0];
                    dsp.seg_hund <= SEG_ACTIVE_LOW ? ~pat_hund : pat_hund;
                    dsp.seg_tens <= SEG_ACTIVE_LOW ? ~pat_tens : pat_tens;
                    dsp.seg_ones <= SEG_ACTIVE_LOW ? ~pat_ones : pat_ones;
                    dsp.done     <= 1'b1;
                    dsp.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
- Downstream consumer of the 8-bit free-running counter value.
- Samples the binary count and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Encodes the digits into 7-segment patterns with leading-zero blanking, ready to drive the board's LED digits.
- Conversion is triggered by an explicit start strobe or by an internal refresh timer, so the display is readable while the counter runs.

Parameters:
- REFRESH_DIV, 12_000_000: clock cycles between auto-triggered conversions; 0 disables auto-trigger.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment drives 0; 0 means a lit segment drives 1.
- BLANK_LEADING, 1: 1 blanks leading zero digits (hundreds, and tens when hundreds=0); the ones digit is never blanked.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- bin_in  input  8  binary value from the upstream counter (q)
- start  input  1  conversion request, sampled only in IDLE
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new outputs are valid
- bcd_hund  output  4  hundreds digit, 0..2
- bcd_tens  output  4  tens digit, 0..9
- bcd_ones  output  4  ones digit, 0..9
- seg_hund  output  7  segments {g,f,e,d,c,b,a}, hundreds
- seg_tens  output  7  segments {g,f,e,d,c,b,a}, tens
- seg_ones  output  7  segments {g,f,e,d,c,b,a}, ones

Behaviour:
- Reset: rst=1 at a clk edge forces the following values, including mid-conversion; any partial result is discarded.
  - state=IDLE, refresh timer=0.
  - busy=0, done=0, all bcd_* = 0.
  - seg_ones = pattern '0'.
  - seg_tens and seg_hund = blank if BLANK_LEADING=1, else pattern '0'.
  - With SEG_ACTIVE_LOW=1: '0'=7'b1000000, blank=7'b1111111.
- States: IDLE -> SHIFT -> ENCODE -> IDLE.
- Trigger: in IDLE, a trigger is start=1 or refresh tick at edge k.
  - bin_in is latched into the shift register, the 12-bit BCD scratch is cleared, iteration counter=0, state goes to SHIFT.
  - busy=1 from after edge k.
- SHIFT: edges k+1..k+8, exactly 8 iterations.
  - Each iteration adds 3 to every scratch nibble that is >=5, then shifts {scratch, bin} left by 1.
  - After the 8th iteration, go to ENCODE.
- ENCODE: at edge k+9, register the bcd_* and seg_* outputs together, pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
- Latency: trigger to done is 9 cycles; outputs change only at the done edge, so they never show intermediate values.
- Back-to-back: start may be reasserted in the cycle done=1; it is accepted, so the next trigger is edge k+10.
- start while busy=1 is ignored (not queued). A refresh tick while busy is also dropped; the timer keeps counting.
- Refresh timer:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - Tick when count = REFRESH_DIV-1.
  - start and tick in the same cycle produce a single conversion.
- Blanking (BLANK_LEADING=1):
  - seg_hund is blank iff hund=0.
  - seg_tens is blank iff hund=0 and tens=0.
  - bcd_* outputs are never blanked.
- Segment map, active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - SEG_ACTIVE_LOW inverts all patterns, including blank.
  - Nibbles 10..15 cannot occur; encode them as blank.
- Width rules: the scratch is 12 bits. Max input 255 gives 0010_0101_0101; the hundreds nibble never exceeds 2.

Decomposition:
- Package seg_pkg holds:
  - state enum {IDLE, SHIFT, ENCODE};
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK (active-high form);
  - ITER_COUNT=8.
- Sub-module seg7_encode: combinational 4-bit digit + blank input -> 7-bit active-high pattern, instantiated 3x. Polarity inversion is applied at the top level.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, seg_ones=1000000, seg_tens=seg_hund=1111111.
- bin_in=255, start pulse at edge k -> done at edge k+9 only; bcd=2/5/5; seg_hund=0100100, seg_tens=0010010, seg_ones=0010010.
- bin_in=7 -> hund/tens blank (1111111), seg_ones=1111000. bin_in=100 -> seg_hund=1111001, seg_tens=1000000 (zero not blanked), seg_ones=1000000.
- start held high continuously with bin_in=42 -> one conversion every 10 cycles; start during busy ignored; bcd=0/4/2 every done.
- REFRESH_DIV=20, start=0, upstream counter driving bin_in -> done every 20 cycles; bcd matches bin_in latched at the tick edge; start coincident with a tick gives one done.
- rst asserted at SHIFT iteration 4 of bin_in=200 -> next cycle busy=0, no done pulse, outputs at reset values; a later start converts 200 correctly.
